// File: rtl/cpu_core_param.sv
// cpu_core_param: multicycle accumulator core with a
// waited memory port, return stack, HALT and fault stop.
module cpu_core_param #(
   parameter int DW = 8,
   parameter int AW = 8,
   parameter int SD = 4
) (
   input  logic          CLK,
   input  logic          CLR,
   output logic          MEM_REQ,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW+7:0] MEM_WDATA,
   input  logic [DW+7:0] MEM_RDATA,
   input  logic          MEM_ACK,
   output logic [DW-1:0] ACC_OUT,
   output logic [AW-1:0] PC_OUT,
   output logic          HALTED,
   output logic          FAULT
);

   localparam int SPW = $clog2(SD + 1);
   localparam int IW  = $clog2(SD);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_INCREMENT,
      S_STOP
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_LOAD,
      OP_AND,
      OP_NOT,
      OP_ADD,
      OP_SUB,
      OP_JMP,
      OP_JZ,
      OP_JNZ,
      OP_JC,
      OP_JNC,
      OP_IN,
      OP_OUT,
      OP_CALL,
      OP_RET,
      OP_HALT
   } op_t;

   state_t        state;
   op_t           op;
   op_t           dec;
   logic [DW+7:0] ir;
   logic [DW-1:0] acc;
   logic [AW-1:0] pc;
   logic          z;
   logic          c;
   logic [SPW-1:0] sp;
   logic [AW-1:0] stk [SD];
   logic          rst_q;
   logic          halted_q;
   logic          fault_q;

   logic [7:0]    opc;
   logic [DW-1:0] opd;
   logic [AW-1:0] tgt;
   logic [AW-1:0] pc_inc;
   logic [DW:0]   sum;
   logic [DW:0]   dif;
   logic [DW-1:0] and_r;
   logic [DW-1:0] not_r;
   logic [SPW-1:0] sp_dec;
   logic          io_op;
   logic          s_full;
   logic          s_empty;
   logic          take;

   assign opc     = ir[DW+7:DW];
   assign opd     = ir[DW-1:0];
   assign tgt     = opd[AW-1:0];
   assign pc_inc  = pc + 1'b1;
   assign sum     = {1'b0, acc} + {1'b0, opd};
   assign dif     = {1'b0, acc} - {1'b0, opd};
   assign and_r   = acc & opd;
   assign not_r   = ~acc;
   assign sp_dec  = sp - 1'b1;
   assign s_full  = (sp == SPW'(SD));
   assign s_empty = (sp == '0);
   assign io_op   = (op == OP_IN) || (op == OP_OUT);

   // The first cycle after reset keeps REQ low so the
   // bus sees a clean idle cycle before the first fetch.
   assign MEM_REQ   = (state == S_FETCH && !rst_q)
                   || (state == S_EXECUTE && io_op);
   assign MEM_WE    = (state == S_EXECUTE) && (op == OP_OUT);
   assign MEM_ADDR  = (state == S_EXECUTE) ? tgt : pc;
   assign MEM_WDATA = {8'h00, acc};
   assign ACC_OUT   = acc;
   assign PC_OUT    = pc;
   assign HALTED    = halted_q;
   assign FAULT     = fault_q;

   // Opcode classification, registered in DECODE.
   always_comb begin
      dec = OP_NOP;
      unique case (1'b1)
         (opc ==? 8'b0000_????): dec = OP_LOAD;
         (opc ==? 8'b0001_????): dec = OP_AND;
         (opc ==? 8'b0011_????): dec = OP_NOT;
         (opc ==? 8'b0100_????): dec = OP_ADD;
         (opc ==? 8'b0110_????): dec = OP_SUB;
         (opc ==? 8'b1000_????): dec = OP_JMP;
         (opc ==? 8'b1001_00??): dec = OP_JZ;
         (opc ==? 8'b1001_01??): dec = OP_JNZ;
         (opc ==? 8'b1001_10??): dec = OP_JC;
         (opc ==? 8'b1001_11??): dec = OP_JNC;
         (opc ==? 8'b1010_????): dec = OP_IN;
         (opc ==? 8'b1100_????): dec = OP_CALL;
         (opc ==? 8'b1101_????): dec = OP_RET;
         (opc ==? 8'b1110_????): dec = OP_OUT;
         (opc ==? 8'b1111_????): dec = OP_HALT;
         default:                dec = OP_NOP;
      endcase
   end

   // Branch condition from the flags left by earlier ALU ops.
   always_comb begin
      take = 1'b0;
      unique case (op)
         OP_JMP:  take = 1'b1;
         OP_JZ:   take = z;
         OP_JNZ:  take = !z;
         OP_JC:   take = c;
         OP_JNC:  take = !c;
         default: take = 1'b0;
      endcase
   end

   // Fetch/decode/execute/increment sequencer and datapath.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= S_FETCH;
         op       <= OP_NOP;
         ir       <= '0;
         pc       <= '0;
         acc      <= '0;
         z        <= 1'b0;
         c        <= 1'b0;
         sp       <= '0;
         rst_q    <= 1'b1;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         rst_q <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (!rst_q && MEM_ACK) begin
                  ir    <= MEM_RDATA;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               op    <= dec;
               state <= S_EXECUTE;
            end
            S_EXECUTE: begin
               unique case (op)
                  OP_LOAD: begin
                     acc   <= opd;
                     state <= S_INCREMENT;
                  end
                  OP_AND: begin
                     acc   <= and_r;
                     z     <= ~|and_r;
                     c     <= 1'b0;
                     state <= S_INCREMENT;
                  end
                  OP_NOT: begin
                     acc   <= not_r;
                     z     <= ~|not_r;
                     c     <= 1'b0;
                     state <= S_INCREMENT;
                  end
                  OP_ADD: begin
                     acc   <= sum[DW-1:0];
                     z     <= ~|sum[DW-1:0];
                     c     <= sum[DW];
                     state <= S_INCREMENT;
                  end
                  OP_SUB: begin
                     acc   <= dif[DW-1:0];
                     z     <= ~|dif[DW-1:0];
                     c     <= dif[DW];
                     state <= S_INCREMENT;
                  end
                  OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                     if (take) begin
                        pc    <= tgt;
                        state <= S_FETCH;
                     end else begin
                        state <= S_INCREMENT;
                     end
                  end
                  OP_IN: begin
                     if (MEM_ACK) begin
                        acc   <= MEM_RDATA[DW-1:0];
                        state <= S_INCREMENT;
                     end
                  end
                  OP_OUT: begin
                     if (MEM_ACK) begin
                        state <= S_INCREMENT;
                     end
                  end
                  OP_CALL: begin
                     if (s_full) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state    <= S_STOP;
                     end else begin
                        stk[sp[IW-1:0]] <= pc_inc;
                        sp    <= sp + 1'b1;
                        pc    <= tgt;
                        state <= S_FETCH;
                     end
                  end
                  OP_RET: begin
                     if (s_empty) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state    <= S_STOP;
                     end else begin
                        pc    <= stk[sp_dec[IW-1:0]];
                        sp    <= sp_dec;
                        state <= S_FETCH;
                     end
                  end
                  OP_HALT: begin
                     halted_q <= 1'b1;
                     state    <= S_STOP;
                  end
                  default: begin
                     state <= S_INCREMENT;
                  end
               endcase
            end
            S_INCREMENT: begin
               pc    <= pc_inc;
               state <= S_FETCH;
            end
            S_STOP: begin
               state <= S_STOP;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed programs against a waited
// memory model, with a write scoreboard.
module tb_cpu_core_param;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int SD = 4;

   logic          CLK = 1'b0;
   logic          CLR = 1'b1;
   logic          MEM_REQ;
   logic          MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [DW+7:0] MEM_WDATA;
   logic [DW+7:0] MEM_RDATA;
   logic          MEM_ACK;
   logic [DW-1:0] ACC_OUT;
   logic [AW-1:0] PC_OUT;
   logic          HALTED;
   logic          FAULT;

   cpu_core_param #(.DW(DW), .AW(AW), .SD(SD)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .MEM_REQ   (MEM_REQ),
      .MEM_WE    (MEM_WE),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WDATA (MEM_WDATA),
      .MEM_RDATA (MEM_RDATA),
      .MEM_ACK   (MEM_ACK),
      .ACC_OUT   (ACC_OUT),
      .PC_OUT    (PC_OUT),
      .HALTED    (HALTED),
      .FAULT     (FAULT)
   );

   always #5 CLK = ~CLK;

   logic [15:0] mem [256];
   int rd_waits = 0;
   int wr_waits = 0;
   int wcnt = 0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0]  a;
      logic [15:0] d;
      int          hold;
   } wr_t;
   wr_t exp_q[$];

   assign MEM_RDATA = mem[MEM_ADDR];
   assign MEM_ACK = MEM_REQ &&
      (wcnt >= (MEM_WE ? wr_waits : rd_waits));

   always @(posedge CLK) begin
      if (MEM_REQ && MEM_ACK && MEM_WE)
         mem[MEM_ADDR] = MEM_WDATA;
      if (!MEM_REQ || MEM_ACK) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   logic [7:0]  w_a;
   logic [15:0] w_d;
   int          w_n = 0;
   logic        w_ok = 1'b1;
   wr_t         w_e;

   always @(negedge CLK) begin
      if (MEM_REQ && MEM_WE) begin
         if (w_n == 0) begin
            w_a  = MEM_ADDR;
            w_d  = MEM_WDATA;
            w_ok = 1'b1;
         end else if (MEM_ADDR !== w_a || MEM_WDATA !== w_d) begin
            w_ok = 1'b0;
         end
         w_n++;
         if (MEM_ACK) begin
            if (exp_q.size() == 0) begin
               chk("wr_unexpected", 32'(MEM_ADDR), 32'hFFFF_FFFF);
            end else begin
               w_e = exp_q.pop_front();
               chk("wr_addr", 32'(MEM_ADDR), 32'(w_e.a));
               chk("wr_data", 32'(MEM_WDATA), 32'(w_e.d));
               chk("wr_hold", w_n, w_e.hold);
               chk("wr_stable", 32'(w_ok), 32'd1);
            end
            w_n = 0;
         end
      end else begin
         w_n = 0;
      end
   end

   task automatic clear_mem;
      for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
   endtask

   task automatic wait_fetch(input logic [7:0] a,
                             output int t);
      t = 0;
      for (int n = 1; n <= 300; n++) begin
         @(negedge CLK);
         if (MEM_REQ && !MEM_WE && MEM_ADDR == a) begin
            t = n;
            break;
         end
      end
      chk($sformatf("reach_%02h", a), 32'(t != 0), 32'd1);
   endtask

   task automatic do_reset;
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      chk("rst_req", 32'(MEM_REQ), 32'd0);
      chk("rst_pc", 32'(PC_OUT), 32'd0);
      chk("rst_acc", 32'(ACC_OUT), 32'd0);
      chk("rst_halt", 32'(HALTED), 32'd0);
      chk("rst_fault", 32'(FAULT), 32'd0);
      CLR = 1'b0;
      @(negedge CLK);
      chk("rel_req", 32'(MEM_REQ), 32'd1);
      chk("rel_addr", 32'(MEM_ADDR), 32'd0);
   endtask

   initial begin
      int t;
      clear_mem();
      mem[8'h00] = 16'h0005;
      mem[8'h01] = 16'h40FB;
      mem[8'h02] = 16'h943F;
      mem[8'h03] = 16'h9C3F;
      mem[8'h04] = 16'h6001;
      mem[8'h05] = 16'h903F;
      mem[8'h06] = 16'h9820;
      mem[8'h20] = 16'h9C3F;
      mem[8'h21] = 16'h00A5;
      mem[8'h22] = 16'hE040;
      mem[8'h23] = 16'h0000;
      mem[8'h24] = 16'hA040;
      mem[8'h25] = 16'h100F;
      mem[8'h26] = 16'h3000;
      mem[8'h27] = 16'hF000;
      mem[8'h3F] = 16'hF000;
      wr_waits = 3;
      exp_q.push_back('{8'h40, 16'h00A5, 4});
      do_reset();

      wait_fetch(8'h01, t);
      chk("load_acc", 32'(ACC_OUT), 32'h05);
      wait_fetch(8'h02, t);
      chk("add_cycles", t, 4);
      chk("add_acc", 32'(ACC_OUT), 32'h00);
      wait_fetch(8'h03, t);
      chk("jnz_fall", t, 4);
      wait_fetch(8'h04, t);
      chk("jnc_fall", t, 4);
      wait_fetch(8'h05, t);
      chk("sub_acc", 32'(ACC_OUT), 32'hFF);
      wait_fetch(8'h06, t);
      chk("jz_fall", t, 4);
      wait_fetch(8'h20, t);
      chk("jc_cycles", t, 3);
      chk("jc_pc", 32'(PC_OUT), 32'h20);
      wait_fetch(8'h21, t);
      chk("jnc_cycles", t, 4);
      wait_fetch(8'h22, t);
      wait_fetch(8'h23, t);
      chk("out_cycles", t, 7);
      wait_fetch(8'h24, t);
      wait_fetch(8'h25, t);
      chk("in_cycles", t, 4);
      chk("in_acc", 32'(ACC_OUT), 32'hA5);
      wait_fetch(8'h26, t);
      chk("and_acc", 32'(ACC_OUT), 32'h05);
      wait_fetch(8'h27, t);
      chk("not_acc", 32'(ACC_OUT), 32'hFA);
      repeat (4) @(negedge CLK);
      chk("halt_halted", 32'(HALTED), 32'd1);
      chk("halt_fault", 32'(FAULT), 32'd0);
      chk("halt_req", 32'(MEM_REQ), 32'd0);
      chk("halt_pc", 32'(PC_OUT), 32'h27);
      chk("wr_pending", exp_q.size(), 0);

      clear_mem();
      mem[8'h03] = 16'hC010;
      mem[8'h10] = 16'hD000;
      mem[8'h04] = 16'hD000;
      do_reset();
      wait_fetch(8'h03, t);
      wait_fetch(8'h10, t);
      chk("call_cycles", t, 3);
      chk("call_pc", 32'(PC_OUT), 32'h10);
      wait_fetch(8'h04, t);
      chk("ret_cycles", t, 3);
      chk("ret_pc", 32'(PC_OUT), 32'h04);
      repeat (4) @(negedge CLK);
      chk("ret2_fault", 32'(FAULT), 32'd1);
      chk("ret2_halted", 32'(HALTED), 32'd1);
      chk("ret2_pc", 32'(PC_OUT), 32'h04);

      clear_mem();
      mem[8'h00] = 16'hD000;
      do_reset();
      repeat (4) @(negedge CLK);
      chk("ret0_fault", 32'(FAULT), 32'd1);
      chk("ret0_halted", 32'(HALTED), 32'd1);
      chk("ret0_pc", 32'(PC_OUT), 32'h00);
      chk("ret0_req", 32'(MEM_REQ), 32'd0);

      clear_mem();
      mem[8'h00] = 16'hC010;
      mem[8'h10] = 16'hC020;
      mem[8'h20] = 16'hC030;
      mem[8'h30] = 16'hC040;
      mem[8'h40] = 16'hC050;
      mem[8'h50] = 16'hF000;
      do_reset();
      wait_fetch(8'h40, t);
      repeat (4) @(negedge CLK);
      chk("ovf_fault", 32'(FAULT), 32'd1);
      chk("ovf_halted", 32'(HALTED), 32'd1);
      chk("ovf_pc", 32'(PC_OUT), 32'h40);
      chk("ovf_req", 32'(MEM_REQ), 32'd0);

      clear_mem();
      mem[8'h00] = 16'h0077;
      mem[8'h01] = 16'h80FF;
      do_reset();
      wait_fetch(8'h01, t);
      wait_fetch(8'hFF, t);
      chk("jmp_cycles", t, 3);
      wait_fetch(8'h00, t);
      chk("wrap_cycles", t, 4);
      chk("wrap_pc", 32'(PC_OUT), 32'h00);
      rd_waits = 5;
      wait_fetch(8'hFF, t);
      chk("wfetch_acc", 32'(ACC_OUT), 32'h77);
      repeat (2) @(negedge CLK);
      chk("wfetch_req", 32'(MEM_REQ), 32'd1);
      chk("wfetch_addr", 32'(MEM_ADDR), 32'hFF);
      do_reset();
      rd_waits = 0;
      wait_fetch(8'h01, t);
      chk("post_rst_acc", 32'(ACC_OUT), 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
